serial_adder_word_ctrl: RTL and testbench

Word-level controller that sequences a one-bit serial adder datapath. It accepts two W-bit operands through a valid/ready handshake and feeds them LSB-first into the bit-serial add step, one bit per clock. It collects the sum bits and the final carry, then presents the W-bit result on a valid/ready output. It sits between word-oriented producers and consumers and the bit-serial arithmetic, so serial adders can be used in word pipelines.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_add_step.sv | 30 +++
 rtl/serial_adder_word_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_word_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and the one-bit full-adder step for the word-level serial adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {carry_out, sum} for one bit position.
   function automatic logic [1:0] add_step(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/serial_add_step.sv
// Bit-serial full-adder step with its carry flop; clr_i zeroes the carry when a new word loads.
module serial_add_step
   import serial_adder_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   input  logic a_i,
   input  logic b_i,
   output logic sum_o,
   output logic carry_next_o
);

   logic       carry_q;
   logic [1:0] step;

   assign step         = add_step(a_i, b_i, carry_q);
   assign sum_o        = step[0];
   assign carry_next_o = step[1];

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         carry_q <= 1'b0;
      end else if (en_i) begin
         carry_q <= step[1];
      end
   end

endmodule

// File: rtl/serial_adder_word_ctrl.sv
// Word-level controller feeding two W-bit operands LSB-first through serial_add_step.
// Optional signed-overflow output is enabled with `define SERIAL_ADDER_WORD_CTRL_OVF_EN.
module serial_adder_word_ctrl
   import serial_adder_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_carry
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
   ,
   output logic         out_overflow
`endif
);

   localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     sa_q, sb_q, r_q;
   logic [W-1:0]     r_d;
   logic             in_ready_q, out_valid_q, out_carry_q;
   logic [W-1:0]     out_sum_q;
   logic             accept, running, last;
   logic             sum_bit, carry_next;

   assign accept  = (state_q == IDLE) && in_valid;
   assign running = (state_q == RUN);
   assign last    = running && (cnt_q == CNT_LAST);
   assign r_d     = {sum_bit, r_q[W-1:1]};

   serial_add_step u_step (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (accept),
      .en_i         (running),
      .a_i          (sa_q[0]),
      .b_i          (sb_q[0]),
      .sum_o        (sum_bit),
      .carry_next_o (carry_next)
   );

   // Operand and result shifters carry no control meaning, so they are not reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         sa_q <= in_a;
         sb_q <= in_b;
      end else if (running) begin
         sa_q <= sa_q >> 1;
         sb_q <= sb_q >> 1;
         r_q  <= r_d;
      end
   end

`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
   logic ovf_q;
   // Carry into the MSB is recovered from the MSB sum and operand bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= (sum_bit ^ sa_q[0] ^ sb_q[0]) ^ carry_next;
      end else if ((state_q == DONE) && out_ready) begin
         ovf_q <= 1'b0;
      end
   end
   assign out_overflow = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_carry_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  out_sum_q   <= r_d;
                  out_carry_q <= carry_next;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_carry = out_carry_q;

endmodule

// File: tb/tb_serial_adder_word_ctrl.sv
// Scoreboard bench for serial_adder_word_ctrl with directed, hand-computed vectors.
module tb_serial_adder_word_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_sum;
   logic         out_carry;
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
   logic         out_overflow;
`endif

   serial_adder_word_ctrl #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
      ,
      .out_overflow (out_overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   lat_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every cycle out_valid is high; pops on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb[0];
            if (!lat_done) begin
               check("latency", cyc - e.acc, W);
               lat_done = 1'b1;
            end
            check("out_sum", {24'b0, out_sum}, {24'b0, e.sum});
            check("out_carry", {31'b0, out_carry}, {31'b0, e.carry});
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
            check("out_overflow", {31'b0, out_overflow}, {31'b0, e.ovf});
`endif
            check("in_ready_while_valid", {31'b0, in_ready}, 32'd0);
            if (out_ready) begin
               void'(sb.pop_front());
               lat_done = 1'b0;
            end
         end
      end
   end

   // Presents operands until accepted, then records the expected result.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] s, input logic c, input logic v);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            e.sum = s; e.carry = c; e.ovf = v; e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         in_valid = 1'b0;
         check("accept_timeout", 32'd1, 32'd0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check("drain", sb.size(), 32'd0);
   endtask

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_valid", {31'b0, seen}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] hold_sum;
      logic         hold_carry;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_sum", {24'b0, out_sum}, 32'd0);
      check("rst_out_carry", {31'b0, out_carry}, 32'd0);
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
      check("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
`endif
      rst = 1'b0;

      // Basic add and carry out
      send(8'h4D, 8'h1D, 8'h6A, 1'b0, 1'b0);
      send(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      drain();

      // Carry isolation between consecutive words
      send(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
      send(8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
      drain();

      // Backpressure with a competing request held during DONE
      out_ready = 1'b0;
      send(8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
      wait_valid();
      hold_sum   = out_sum;
      hold_carry = out_carry;
      in_valid = 1'b1;
      in_a     = 8'h11;
      in_b     = 8'h22;
      repeat (5) begin
         @(negedge clk);
         check("bp_sum_stable", {24'b0, out_sum}, {24'b0, hold_sum});
         check("bp_carry_stable", {31'b0, out_carry}, {31'b0, hold_carry});
         check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      send(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
      drain();

      // Reset while cnt == 3
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 8'h55;
      in_b     = 8'h0F;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrun_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrun_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrun_out_sum", {24'b0, out_sum}, 32'd0);
      check("midrun_out_carry", {31'b0, out_carry}, 32'd0);
`ifdef SERIAL_ADDER_WORD_CTRL_OVF_EN
      check("midrun_out_overflow", {31'b0, out_overflow}, 32'd0);
`endif
      send(8'h03, 8'h04, 8'h07, 1'b0, 1'b0);
      drain();

      // Signed overflow cases
      send(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      send(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      check("idle_out_valid", {31'b0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
